// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, one-byte buffered output
//            with valid/ready handshake, frame-error and overrun pulses.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int SYSTEM_CYCLES = 25_000_000,
    parameter int BAUDRATE      = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rx_in,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
);

    // CYCLES_PER_BIT must be at least 4 so that HALF_BIT - 1 stays positive.
    localparam int CYCLES_PER_BIT = SYSTEM_CYCLES / BAUDRATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);

    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic             sync1_q, sync1_d;
    logic             rxs_q, rxs_d;
    logic             rxs_prev_q, rxs_prev_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        sync1_d     = uart_rx_in;
        rxs_d       = sync1_q;
        rxs_prev_d  = rxs_q;
        state_d     = state_q;
        cnt_d       = cnt_q + c_CNT_ONE;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                if (!rxs_q && rxs_prev_q) begin
                    state_d = c_START;
                end
            end
            c_START: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rxs_q ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = c_STOP;
                    end
                end
            end
            c_STOP: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = c_IDLE;
                    if (rxs_q) begin
                        // A simultaneous consume frees the buffer, so no overrun.
                        data_d    = shift_q;
                        valid_d   = 1'b1;
                        overrun_d = valid_q & ~ready;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= c_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx: directed scenarios plus random
//            frames compared against a byte-level receiver model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int SYS  = 160;
    localparam int BAUD = 10;
    localparam int CPB  = SYS / BAUD;
    localparam int HALF = CPB / 2;
    // Line drive -> two synchronizer stages -> edge-detect stage, then half a bit
    // plus nine bit times to the stop sample.
    localparam int STOP_EDGE = 3 + HALF + 9 * CPB;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic       uart_rx_in = 1'b1;
    logic       ready      = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int rise_c  = -1;

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;

    uart_rx #(
        .SYSTEM_CYCLES(SYS),
        .BAUDRATE     (BAUD)
    ) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .uart_rx_in(uart_rx_in),
        .ready     (ready),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Counting high cycles on the negedge also catches pulses wider than one cycle.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rx_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic consume(input string tag);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        m_valid = 1'b0;
        check_eq({tag, "_valid_after_ready"}, {31'd0, valid}, {31'd0, m_valid});
    endtask

    // Sends one 8N1 frame; leaves the stop-bit level on the line afterwards.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_ok,
                              input logic rdy_stop);
        int         fe0;
        int         ov0;
        logic       vprev;
        logic [9:0] bits;
        logic       exp_fe;
        logic       exp_ov;
        fe0    = fe_cnt;
        ov0    = ov_cnt;
        bits   = {stop_ok, b, 1'b0};
        rise_c = -1;
        for (int c = 0; c < 10 * CPB; c++) begin
            uart_rx_in = bits[c / CPB];
            ready      = rdy_stop && (c == STOP_EDGE - 1);
            vprev      = valid;
            tick();
            if (!vprev && valid && rise_c < 0) rise_c = c + 1;
        end
        ready = 1'b0;

        exp_fe = !stop_ok;
        exp_ov = stop_ok && m_valid && !rdy_stop;
        if (stop_ok) begin
            m_data  = b;
            m_valid = 1'b1;
        end else begin
            m_valid = m_valid && !rdy_stop;
        end
        check_eq({tag, "_data"},      {24'd0, data},  {24'd0, m_data});
        check_eq({tag, "_valid"},     {31'd0, valid}, {31'd0, m_valid});
        check_eq({tag, "_frame_err"}, fe_cnt - fe0,   {31'd0, exp_fe});
        check_eq({tag, "_overrun"},   ov_cnt - ov0,   {31'd0, exp_ov});
    endtask

    initial begin
        int         fe0;
        int         ov0;
        logic [9:0] pbits;

        // Reset state
        resetn = 1'b0;
        tick(); tick(); tick();
        check_eq("rst_data",  {24'd0, data},  32'h00);
        check_eq("rst_valid", {31'd0, valid}, 32'h0);
        check_eq("rst_fe",    {31'd0, frame_err}, 32'h0);
        check_eq("rst_ov",    {31'd0, overrun},   32'h0);
        resetn = 1'b1;
        idle(10);

        // 0x55 with latency measurement and handshake
        send_frame("b55", 8'h55, 1'b1, 1'b0);
        check_eq("b55_latency", rise_c, STOP_EDGE);
        idle(20);
        check_eq("b55_valid_hold", {31'd0, valid}, 32'h1);
        consume("b55");

        // Short low glitch must be rejected as a false start
        fe0 = fe_cnt;
        uart_rx_in = 1'b0;
        repeat (4) tick();
        idle(40);
        check_eq("glitch_valid", {31'd0, valid}, 32'h0);
        check_eq("glitch_fe",    fe_cnt - fe0,   32'h0);
        send_frame("bA3", 8'hA3, 1'b1, 1'b0);

        // Framing error followed by a held-low break
        send_frame("b12_ferr", 8'h12, 1'b0, 1'b0);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        repeat (100) tick();
        check_eq("break_fe",    fe_cnt - fe0,   32'h0);
        check_eq("break_ov",    ov_cnt - ov0,   32'h0);
        check_eq("break_data",  {24'd0, data},  {24'd0, m_data});
        check_eq("break_valid", {31'd0, valid}, {31'd0, m_valid});
        idle(10);
        consume("bA3");

        // Back-to-back frames, unconsumed first byte
        send_frame("ovr_b01", 8'h01, 1'b1, 1'b0);
        send_frame("ovr_bFE", 8'hFE, 1'b1, 1'b0);
        idle(5);
        consume("ovr");

        // Consume coincident with the second stop sample
        send_frame("rdy_b01", 8'h01, 1'b1, 1'b0);
        send_frame("rdy_bFE", 8'hFE, 1'b1, 1'b1);
        idle(5);
        consume("rdy");

        // Reset in the middle of bit 4 of 0x77
        fe0   = fe_cnt;
        ov0   = ov_cnt;
        pbits = {1'b1, 8'h77, 1'b0};
        for (int c = 0; c < 5 * CPB + HALF; c++) begin
            uart_rx_in = pbits[c / CPB];
            tick();
        end
        resetn = 1'b0;
        #1;
        check_eq("midrst_valid_async", {31'd0, valid}, 32'h0);
        uart_rx_in = 1'b1;
        tick(); tick();
        resetn = 1'b1;
        m_data  = 8'h00;
        m_valid = 1'b0;
        idle(10 * CPB);
        check_eq("midrst_data",  {24'd0, data},  32'h00);
        check_eq("midrst_valid", {31'd0, valid}, 32'h0);
        check_eq("midrst_fe",    fe_cnt - fe0,   32'h0);
        check_eq("midrst_ov",    ov_cnt - ov0,   32'h0);
        send_frame("b3C", 8'h3C, 1'b1, 1'b0);
        idle(3);

        // Random frames against the byte-level model
        for (int i = 0; i < 24; i++) begin
            logic [7:0] rb;
            logic       rstop;
            logic       rrdy;
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 7) != 0);
            rrdy  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) consume("rnd_pre");
            send_frame("rnd", rb, rstop, rrdy);
            idle($urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
